// File: rtl/sbm_digit_accumulator_pkg.sv
// Shared types and elaboration helpers for the digit accumulator.
// Holds the FSM encoding and the operand/digit geometry functions.
package sbm_digit_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned digits_of(input int unsigned sizeb,
                                            input int unsigned sizeof_digits);
    return sizeb / sizeof_digits;
  endfunction

  function automatic bit digits_ok(input int unsigned sizeb, input int unsigned sizeof_digits);
    return (sizeof_digits != 0) && ((sizeb % sizeof_digits) == 0) && (sizeb >= sizeof_digits);
  endfunction

endpackage

// File: rtl/sbm_digit_accumulator_if.sv
// Digit-multiplier response interface: controller streams partial products,
// accumulator returns the assembled product with a held done flag.
interface sbm_digit_accumulator_if #(
  parameter int unsigned PpWidth = 1032,
  parameter int unsigned CWidth  = 2048
);
  logic               start;
  logic [PpWidth-1:0] pp_in;
  logic               pp_valid;
  logic               pp_ready;
  logic [CWidth-1:0]  c;
  logic               done;

  modport master (
    output start, pp_in, pp_valid,
    input  pp_ready, c, done
  );

  modport slave (
    input  start, pp_in, pp_valid,
    output pp_ready, c, done
  );
endinterface

// File: rtl/sbm_acc_adder.sv
// Combinational slice adder: adds one partial product into the aligned
// accumulator window, keeping the carry in the extra top bit.
module sbm_acc_adder #(
  parameter int unsigned SIZEA         = 1024,
  parameter int unsigned SIZEOF_DIGITS = 8
) (
  input  logic [SIZEA+SIZEOF_DIGITS:0]   slice,
  input  logic [SIZEA+SIZEOF_DIGITS-1:0] pp,
  output logic [SIZEA+SIZEOF_DIGITS:0]   sum
);
  assign sum = slice + {1'b0, pp};
endmodule

// File: rtl/sbm_digit_accumulator.sv
// Shift-add accumulator for the digitized schoolbook multiplier: takes one
// partial product per B digit, LSB digit first, and presents the full product.
module sbm_digit_accumulator
  import sbm_digit_accumulator_pkg::*;
#(
  parameter int unsigned SIZEA         = 1024,
  parameter int unsigned SIZEB         = 1024,
  parameter int unsigned SIZEOF_DIGITS = 8
) (
  input logic                   clk,
  input logic                   rst,
  sbm_digit_accumulator_if.slave bus
);
  localparam int unsigned DIGITS  = digits_of(SIZEB, SIZEOF_DIGITS);
  localparam int unsigned CNT_W   = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);
  localparam int unsigned SLICE_W = SIZEA + SIZEOF_DIGITS + 1;
  // One spare bit above the last window so the slice carry always has a home.
  localparam int unsigned ACC_W   = (SIZEA + SIZEB + 1 > 2 * SIZEA) ? SIZEA + SIZEB + 1
                                                                     : 2 * SIZEA;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  if (!digits_ok(SIZEB, SIZEOF_DIGITS)) begin : gen_cfg_err
    $error("SIZEB must be a non-zero multiple of SIZEOF_DIGITS");
  end

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic               done_q;

  logic [31:0]        off;
  logic [SLICE_W-1:0] slice;
  logic [SLICE_W-1:0] sum;

  // The partial sum below the window never reaches past it for in-range
  // operands, so only the SIZEA+SIZEOF_DIGITS+1 window needs an adder.
  assign off   = SIZEOF_DIGITS * 32'(cnt_q);
  assign slice = acc_q[off +: SLICE_W];

  sbm_acc_adder #(
    .SIZEA         (SIZEA),
    .SIZEOF_DIGITS (SIZEOF_DIGITS)
  ) u_adder (
    .slice (slice),
    .pp    (bus.pp_in),
    .sum   (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        ST_ACC: begin
          // A restart wins over a word presented in the same cycle.
          if (bus.start) begin
            cnt_q <= '0;
            acc_q <= '0;
          end else if (bus.pp_valid) begin
            acc_q[off +: SLICE_W] <= sum;
            if (cnt_q == LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          acc_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pp_ready = (state_q == ST_ACC);
  assign bus.c        = acc_q[2*SIZEA-1:0];
  assign bus.done     = done_q;

endmodule

// File: tb/tb_sbm_digit_accumulator.sv
// Self-checking bench: a 16x16/8-bit instance for vectors and random products,
// plus a default-size instance for the full 128-digit path.
module tb_sbm_digit_accumulator;

  logic clk;
  logic rst;

  sbm_digit_accumulator_if #(.PpWidth(24), .CWidth(32)) sb ();
  sbm_digit_accumulator_if #(.PpWidth(1032), .CWidth(2048)) bb ();

  sbm_digit_accumulator #(
    .SIZEA         (16),
    .SIZEB         (16),
    .SIZEOF_DIGITS (8)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sb.slave)
  );

  sbm_digit_accumulator u_big (
    .clk (clk),
    .rst (rst),
    .bus (bb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [23:0] pp0;
    logic [23:0] pp1;
    int          gap;
    logic [31:0] exp_c;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [2047:0] got,
                          input logic [2047:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got low=%0h ones=%0d expected low=%0h ones=%0d", name, got[63:0],
               $countones(got), exp[63:0], $countones(exp));
    end
  endtask

  task automatic s_idle(input int n);
    sb.start    = 1'b0;
    sb.pp_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic s_start();
    sb.start    = 1'b1;
    sb.pp_valid = 1'b0;
    tick();
    sb.start = 1'b0;
  endtask

  task automatic s_word(input logic [23:0] pp);
    sb.pp_in    = pp;
    sb.pp_valid = 1'b1;
    tick();
    sb.pp_valid = 1'b0;
  endtask

  initial begin
    logic [15:0]   a;
    logic [15:0]   b;
    logic [31:0]   exp_c;
    logic [1023:0] wa;
    logic [1023:0] wb;
    logic [2047:0] wexp;

    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{pp0: 24'hFEFF01, pp1: 24'hFEFF01, gap: 0, exp_c: 32'hFFFE0001};
    vecs[1] = '{pp0: 24'h0000AB, pp1: 24'h000001, gap: 3, exp_c: 32'h000001AB};
    vecs[2] = '{pp0: 24'h001234, pp1: 24'h002468, gap: 1, exp_c: 32'h00247A34};
    vecs[3] = '{pp0: 24'h000000, pp1: 24'h000000, gap: 2, exp_c: 32'h00000000};

    rst = 1'b1;
    sb.start = 1'b0; sb.pp_valid = 1'b0; sb.pp_in = '0;
    bb.start = 1'b0; bb.pp_valid = 1'b0; bb.pp_in = '0;
    repeat (2) tick();
    chk("reset_c", 64'(sb.c), 64'd0);
    chk("reset_done", 64'(sb.done), 64'd0);
    chk("reset_ready", 64'(sb.pp_ready), 64'd0);
    rst = 1'b0;
    tick();

    // Words offered while idle must be ignored.
    s_word(24'hFFFFFF);
    chk("idle_ignore_c", 64'(sb.c), 64'd0);
    chk("idle_ready", 64'(sb.pp_ready), 64'd0);

    for (int i = 0; i < 4; i++) begin
      s_start();
      chk($sformatf("vec%0d_ready", i), 64'(sb.pp_ready), 64'd1);
      s_idle(vecs[i].gap);
      s_word(vecs[i].pp0);
      chk($sformatf("vec%0d_done_mid", i), 64'(sb.done), 64'd0);
      s_idle(vecs[i].gap);
      s_word(vecs[i].pp1);
      chk($sformatf("vec%0d_done", i), 64'(sb.done), 64'd1);
      chk($sformatf("vec%0d_c", i), 64'(sb.c), 64'(vecs[i].exp_c));
      chk($sformatf("vec%0d_ready_done", i), 64'(sb.pp_ready), 64'd0);
    end

    // Async reset mid-product clears outputs without a clock edge.
    s_start();
    s_word(24'h0000AB);
    rst = 1'b1;
    #1;
    chk("async_rst_c", 64'(sb.c), 64'd0);
    chk("async_rst_done", 64'(sb.done), 64'd0);
    chk("async_rst_ready", 64'(sb.pp_ready), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle_ready", 64'(sb.pp_ready), 64'd0);

    // Abort: a start coinciding with a valid word drops that word.
    s_start();
    s_word(24'h00FFFF);
    sb.start    = 1'b1;
    sb.pp_valid = 1'b1;
    sb.pp_in    = 24'h123456;
    tick();
    sb.start    = 1'b0;
    sb.pp_valid = 1'b0;
    chk("abort_cleared_c", 64'(sb.c), 64'd0);
    s_word(24'h000002);
    s_word(24'h000003);
    chk("abort_done", 64'(sb.done), 64'd1);
    chk("abort_c", 64'(sb.c), 64'h302);

    // Words in ST_DONE are ignored; a start right after done begins afresh.
    s_word(24'hFFFFFF);
    chk("done_hold_c", 64'(sb.c), 64'h302);
    chk("done_hold_done", 64'(sb.done), 64'd1);
    s_start();
    chk("b2b_done_drop", 64'(sb.done), 64'd0);
    chk("b2b_c_clear", 64'(sb.c), 64'd0);
    s_word(24'h000005);
    s_word(24'h000007);
    chk("b2b_c", 64'(sb.c), 64'h705);
    chk("b2b_done", 64'(sb.done), 64'd1);

    // Random products: reference is simply a*b.
    for (int t = 0; t < 24; t++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      exp_c = 32'(a) * 32'(b);
      s_start();
      for (int d = 0; d < 2; d++) begin
        s_idle($urandom_range(0, 2));
        s_word(24'(a) * 24'(b[8*d +: 8]));
      end
      chk($sformatf("rand%0d_done", t), 64'(sb.done), 64'd1);
      chk($sformatf("rand%0d_c a=%0h b=%0h", t, a, b), 64'(sb.c), 64'(exp_c));
    end

    // Default size: a=1, b=2^1023 -> only the top digit is non-zero.
    bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    bb.pp_in    = '0;
    bb.pp_valid = 1'b1;
    repeat (127) tick();
    bb.pp_valid = 1'b0;
    chk("big_done_before_last", 64'(bb.done), 64'd0);
    bb.pp_in    = 1032'h80;
    bb.pp_valid = 1'b1;
    tick();
    bb.pp_valid = 1'b0;
    wexp = '0;
    wexp[1023] = 1'b1;
    chk("big_done", 64'(bb.done), 64'd1);
    chk_wide("big_c_pow2", bb.c, wexp);

    // Default size, random wide operands against a full-width multiply.
    for (int k = 0; k < 32; k++) begin
      wa[32*k +: 32] = $urandom;
      wb[32*k +: 32] = $urandom;
    end
    wexp = 2048'(wa) * 2048'(wb);
    bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    for (int d = 0; d < 128; d++) begin
      bb.pp_in    = 1032'(wa) * 1032'(wb[8*d +: 8]);
      bb.pp_valid = (d % 5) != 3;
      tick();
      if ((d % 5) == 3) begin
        bb.pp_valid = 1'b1;
        tick();
      end
    end
    bb.pp_valid = 1'b0;
    chk("big_rand_done", 64'(bb.done), 64'd1);
    chk_wide("big_rand_c", bb.c, wexp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
